sram_init_master: RTL and testbench
===================================

SRAM_INIT_MASTER -- requirements
Module: sram_init_master

Interface
REQ-001 DATA_WIDTH, 64, data width in bits of the SRAM word.
REQ-002 NUM_WORDS, 1024, SRAM depth; AW = $clog2(NUM_WORDS), BW = (DATA_WIDTH+7)/8.
REQ-003 INIT_VALUE, '0, DATA_WIDTH-bit pattern written to every word during initialisation.
REQ-004 clk_i  in  1  single clock, all logic rising-edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 init_i  in  1  pulse requesting a re-initialisation of the whole SRAM.
REQ-007 init_done_o  out  1  high while in SERVE.
REQ-008 req_valid_i / req_ready_o  in / out  1 / 1  host request handshake.
REQ-009 req_we_i, req_addr_i, req_wdata_i, req_be_i  in  1, AW, DATA_WIDTH, BW  host request payload.
REQ-010 rsp_valid_o / rsp_ready_i  out / in  1 / 1  read response handshake.
REQ-011 rsp_rdata_o  out  DATA_WIDTH  read data.
REQ-012 sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o  out  1, 1, AW, DATA_WIDTH, BW  SRAM port.
REQ-013 sram_rdata_i  in  DATA_WIDTH  SRAM read data, valid exactly one cycle after a read request (we=0).

Function
REQ-014 FSM states IDLE, INIT, SERVE; IDLE -> INIT unconditionally on the first clock after reset release.
REQ-015 INIT: every cycle drive sram_req_o=1, sram_we_o=1, sram_be_o all ones, sram_wdata_o=INIT_VALUE, sram_addr_o=fill counter; counter increments by 1 each cycle.
REQ-016 INIT with counter = NUM_WORDS-1 -> SERVE next cycle; counter clears to 0; init takes exactly NUM_WORDS cycles.
REQ-017 req_ready_o = (state==SERVE) && !init_i && (fifo_count + rd_inflight < 2); independent of req_valid_i and payload.
REQ-018 Request accepted when req_valid_i && req_ready_o; same cycle sram_req_o=1 and SRAM port carries req_we_i/addr/wdata/be combinationally.
REQ-019 No accepted request -> sram_req_o=0 in SERVE and IDLE.
REQ-020 Accepted read sets rd_inflight for one cycle; next cycle sram_rdata_i is pushed into a 2-entry response FIFO.
REQ-021 Writes produce no response.
REQ-022 rsp_valid_o = FIFO non-empty; rsp_rdata_o = FIFO head; pop on rsp_valid_o && rsp_ready_i; simultaneous push and pop allowed, count unchanged.
REQ-023 Credit rule guarantees FIFO never overflows; push while full is a design error (assertion).
REQ-024 Responses returned in request order.
REQ-025 init_i in SERVE -> INIT next cycle; host request not accepted that cycle; an inflight read still lands in the FIFO; FIFO keeps draining during INIT.
REQ-026 init_i ignored in IDLE and INIT.

Reset
REQ-027 Asynchronous assertion: state=IDLE, counter=0, rd_inflight=0, FIFO empty.
REQ-028 Outputs during reset: sram_req_o=0, req_ready_o=0, rsp_valid_o=0, init_done_o=0.
REQ-029 Reset mid-INIT or mid-transaction discards FIFO contents and inflight read; full init restarts after release.

Verification
REQ-030 Release reset, NUM_WORDS=16 -> 16 consecutive writes addr 0..15 of INIT_VALUE, be all ones, init_done_o high on cycle 18 after release.
REQ-031 Write 0xDEAD_BEEF to addr 5 be=0x0F, read addr 5 -> rsp_rdata_o low 32 bits 0xDEADBEEF, upper bits INIT_VALUE.
REQ-032 Reads addr 1,2,3 back-to-back with rsp_ready_i=0 -> third not accepted (req_ready_o=0), FIFO holds 2; raise rsp_ready_i -> data 1,2 then 3 in order.
REQ-033 init_i in same cycle as req_valid_i -> request not accepted; INIT runs full length; earlier pending read response still delivered.
REQ-034 Assert rst_ni=0 during INIT at counter 7 -> sram_req_o drops immediately; after release fill restarts at addr 0.
REQ-035 Random read/write traffic with random rsp_ready_i vs. reference memory model -> all read data match, no FIFO overflow.

Source files
------------

// File: rtl/sram_init_master_if.sv
// Host-side request/response bundle for sram_init_master.
// The host drives the master modport, the controller takes the slave.
interface sram_init_master_if #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NUM_WORDS  = 1024,
   localparam int unsigned AW =
      (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
   localparam int unsigned BW = (DATA_WIDTH + 7) / 8
);

   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_we_i;
   logic [AW-1:0]         req_addr_i;
   logic [DATA_WIDTH-1:0] req_wdata_i;
   logic [BW-1:0]         req_be_i;

   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic [DATA_WIDTH-1:0] rsp_rdata_o;

   modport master (
      output req_valid_i,
      output req_we_i,
      output req_addr_i,
      output req_wdata_i,
      output req_be_i,
      output rsp_ready_i,
      input  req_ready_o,
      input  rsp_valid_o,
      input  rsp_rdata_o
   );

   modport slave (
      input  req_valid_i,
      input  req_we_i,
      input  req_addr_i,
      input  req_wdata_i,
      input  req_be_i,
      input  rsp_ready_i,
      output req_ready_o,
      output rsp_valid_o,
      output rsp_rdata_o
   );

endinterface

// File: rtl/sram_init_master.sv
// SRAM front-end: fills the array with INIT_VALUE, then serves
// host reads/writes with a 2-entry in-order response FIFO.
module sram_init_master #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NUM_WORDS  = 1024,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
   localparam int unsigned AW =
      (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
   localparam int unsigned BW = (DATA_WIDTH + 7) / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  init_i,
   output logic                  init_done_o,
   sram_init_master_if.slave     host,
   output logic                  sram_req_o,
   output logic                  sram_we_o,
   output logic [AW-1:0]         sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_wdata_o,
   output logic [BW-1:0]         sram_be_o,
   input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      SERVE
   } state_t;

   state_t                state_q;
   logic [AW-1:0]         cnt_q;
   logic                  rd_inflight_q;
   logic [DATA_WIDTH-1:0] fifo_q [2];
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [1:0]            count_q;

   logic                  fill;
   logic                  last;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic [1:0]            used;

   assign fill = (state_q == INIT);
   assign last = (cnt_q == AW'(NUM_WORDS - 1));

   // An inflight read already owns a FIFO slot.
   assign used = count_q + {1'b0, rd_inflight_q};

   assign host.req_ready_o = (state_q == SERVE)
                           && !init_i
                           && (used < 2'd2);

   assign accept = host.req_valid_i
                && host.req_ready_o;

   assign push = rd_inflight_q;
   assign pop  = host.rsp_valid_o
              && host.rsp_ready_i;

   assign host.rsp_valid_o = (count_q != 2'd0);
   assign host.rsp_rdata_o = fifo_q[rd_ptr_q];

   assign init_done_o = (state_q == SERVE);

   always_comb begin
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_be_o    = '0;
      unique case (1'b1)
         fill: begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = cnt_q;
            sram_wdata_o = INIT_VALUE;
            sram_be_o    = '1;
         end
         accept: begin
            sram_req_o   = 1'b1;
            sram_we_o    = host.req_we_i;
            sram_addr_o  = host.req_addr_i;
            sram_wdata_o = host.req_wdata_i;
            sram_be_o    = host.req_be_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         rd_inflight_q <= 1'b0;
      end else begin
         rd_inflight_q <= accept && !host.req_we_i;
         unique case (state_q)
            IDLE: begin
               state_q <= INIT;
               cnt_q   <= '0;
            end
            INIT: begin
               if (last) begin
                  state_q <= SERVE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + AW'(1);
               end
            end
            SERVE: begin
               if (init_i) begin
                  state_q <= INIT;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Read data arrives one cycle after the request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_q   <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= sram_rdata_i;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

`ifndef SYNTHESIS
   a_no_overflow: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      !(push && (count_q == 2'd2) && !pop)
   );
`endif

endmodule

// File: tb/tb_sram_init_master.sv
// Directed and random checks of sram_init_master
// against a 1-cycle-latency SRAM model.
module tb_sram_init_master;

   localparam int DW = 64;
   localparam int NW = 16;
   localparam int AW = 4;
   localparam int BW = 8;
   localparam logic [63:0] IV = 64'hA5A5_A5A5_5A5A_5A5A;
   localparam logic [63:0] V1 = 64'h1111_2222_3333_4444;
   localparam logic [63:0] V2 = 64'h5555_6666_7777_8888;
   localparam logic [63:0] V3 = 64'h9999_AAAA_BBBB_CCCC;
   localparam logic [63:0] W5 = 64'hA5A5_A5A5_DEAD_BEEF;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          init = 1'b0;
   logic          init_done;
   logic          sram_req;
   logic          sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic [BW-1:0] sram_be;
   logic [DW-1:0] sram_rdata;

   logic [DW-1:0] mem [NW];
   logic [DW-1:0] ref_mem [NW];
   logic [DW-1:0] exp_q [$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_init_master_if #(
      .DATA_WIDTH(DW),
      .NUM_WORDS (NW)
   ) bus ();

   sram_init_master #(
      .DATA_WIDTH(DW),
      .NUM_WORDS (NW),
      .INIT_VALUE(IV)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .init_i      (init),
      .init_done_o (init_done),
      .host        (bus),
      .sram_req_o  (sram_req),
      .sram_we_o   (sram_we),
      .sram_addr_o (sram_addr),
      .sram_wdata_o(sram_wdata),
      .sram_be_o   (sram_be),
      .sram_rdata_i(sram_rdata)
   );

   always_ff @(posedge clk) begin
      if (sram_req) begin
         if (sram_we) begin
            for (int b = 0; b < BW; b++) begin
               if (sram_be[b]) begin
                  mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
               end
            end
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic drive(input logic v,
                        input logic we,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d,
                        input logic [BW-1:0] be);
      bus.req_valid_i = v;
      bus.req_we_i    = we;
      bus.req_addr_i  = a;
      bus.req_wdata_i = d;
      bus.req_be_i    = be;
   endtask

   task automatic chk_fill(input string tag, input int j);
      chk($sformatf("%s_fill%0d", tag, j),
          128'({sram_req, sram_we, sram_addr,
                sram_be, sram_wdata, init_done}),
          128'({1'b1, 1'b1, 4'(j),
                8'hFF, IV, 1'b0}));
   endtask

   task automatic expect_fill(input string tag, input int first);
      for (int j = first; j < NW; j++) begin
         nxt(); #1;
         chk_fill(tag, j);
      end
      nxt(); #1;
      chk({tag, "_done"},
          128'({init_done, sram_req}), 128'(2'b10));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      logic          pend;
      logic          pwe;
      logic [AW-1:0] paddr;
      logic [DW-1:0] pd;
      logic [BW-1:0] pbe;

      drive(1'b0, 1'b0, '0, '0, '0);
      bus.rsp_ready_i = 1'b0;

      #12;
      chk("reset_outs",
          128'({sram_req, bus.req_ready_o,
                bus.rsp_valid_o, init_done}), 128'(4'b0000));

      nxt(); rst_n = 1'b1; #1;
      chk("boot_idle", 128'({sram_req, init_done}), 128'(2'b00));
      expect_fill("boot", 0);

      // Partial-byte write then read back.
      nxt(); drive(1'b1, 1'b1, 4'd5, 64'hDEAD_BEEF, 8'h0F); #1;
      chk("wr5",
          128'({bus.req_ready_o, sram_req, sram_we,
                sram_addr, sram_be, sram_wdata}),
          128'({1'b1, 1'b1, 1'b1, 4'd5, 8'h0F,
                64'hDEAD_BEEF}));
      nxt(); drive(1'b1, 1'b0, 4'd5, '0, '0); #1;
      chk("rd5_req",
          128'({bus.req_ready_o, sram_req, sram_we, sram_addr}),
          128'({1'b1, 1'b1, 1'b0, 4'd5}));
      nxt(); drive(1'b0, 1'b0, '0, '0, '0); #1;
      chk("rd5_lat", 128'(bus.rsp_valid_o), 128'(1'b0));
      nxt(); #1;
      chk("rd5_data",
          128'({bus.rsp_valid_o, bus.rsp_rdata_o}),
          128'({1'b1, W5}));
      bus.rsp_ready_i = 1'b1;
      nxt(); bus.rsp_ready_i = 1'b0; #1;
      chk("rd5_pop", 128'(bus.rsp_valid_o), 128'(1'b0));

      // Back-pressure: third read must wait for a free slot.
      nxt(); drive(1'b1, 1'b1, 4'd1, V1, 8'hFF);
      nxt(); drive(1'b1, 1'b1, 4'd2, V2, 8'hFF);
      nxt(); drive(1'b1, 1'b1, 4'd3, V3, 8'hFF);
      nxt(); drive(1'b1, 1'b0, 4'd1, '0, '0); #1;
      chk("q_rd1", 128'(bus.req_ready_o), 128'(1'b1));
      nxt(); drive(1'b1, 1'b0, 4'd2, '0, '0); #1;
      chk("q_rd2", 128'(bus.req_ready_o), 128'(1'b1));
      nxt(); drive(1'b1, 1'b0, 4'd3, '0, '0); #1;
      chk("q_rd3_block",
          128'({bus.req_ready_o, sram_req}), 128'(2'b00));
      nxt(); #1;
      chk("q_full",
          128'({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o}),
          128'({1'b0, 1'b1, V1}));
      bus.rsp_ready_i = 1'b1;
      nxt(); #1;
      chk("q_second",
          128'({bus.req_ready_o, bus.rsp_rdata_o}),
          128'({1'b1, V2}));
      nxt(); drive(1'b0, 1'b0, '0, '0, '0); #1;
      chk("q_lat3", 128'(bus.rsp_valid_o), 128'(1'b0));
      nxt(); #1;
      chk("q_third",
          128'({bus.rsp_valid_o, bus.rsp_rdata_o}),
          128'({1'b1, V3}));
      nxt(); bus.rsp_ready_i = 1'b0; #1;
      chk("q_empty", 128'(bus.rsp_valid_o), 128'(1'b0));

      // Re-init collides with a request; pending read survives.
      nxt(); drive(1'b1, 1'b0, 4'd5, '0, '0); #1;
      chk("pend_req", 128'(sram_req), 128'(1'b1));
      nxt(); drive(1'b1, 1'b0, 4'd2, '0, '0); init = 1'b1; #1;
      chk("init_block",
          128'({bus.req_ready_o, sram_req, init_done}),
          128'(3'b001));
      nxt(); drive(1'b0, 1'b0, '0, '0, '0);
      init = 1'b0; bus.rsp_ready_i = 1'b1; #1;
      chk_fill("reinit", 0);
      chk("init_pend_rsp",
          128'({bus.rsp_valid_o, bus.rsp_rdata_o}),
          128'({1'b1, W5}));
      expect_fill("reinit", 1);
      chk("init_drained", 128'(bus.rsp_valid_o), 128'(1'b0));
      bus.rsp_ready_i = 1'b0;
      nxt(); drive(1'b1, 1'b0, 4'd5, '0, '0);
      nxt(); drive(1'b0, 1'b0, '0, '0, '0);
      nxt(); #1;
      chk("reinit_rd5",
          128'({bus.rsp_valid_o, bus.rsp_rdata_o}),
          128'({1'b1, IV}));

      // Reset in the middle of a fill with a response queued.
      nxt(); drive(1'b1, 1'b0, 4'd3, '0, '0);
      nxt(); drive(1'b0, 1'b0, '0, '0, '0); init = 1'b1;
      nxt(); init = 1'b0; #1;
      chk_fill("mid", 0);
      for (int j = 1; j <= 7; j++) begin
         nxt(); #1;
         chk_fill("mid", j);
      end
      chk("mid_queued", 128'(bus.rsp_valid_o), 128'(1'b1));
      rst_n = 1'b0; #1;
      chk("rst_async",
          128'({sram_req, bus.rsp_valid_o,
                bus.req_ready_o, init_done}), 128'(4'b0000));
      nxt(); nxt(); rst_n = 1'b1; #1;
      chk("rst_idle", 128'({sram_req, init_done}), 128'(2'b00));
      expect_fill("rst", 0);
      chk("rst_fifo_empty", 128'(bus.rsp_valid_o), 128'(1'b0));

      // Random traffic against a reference memory.
      for (int i = 0; i < NW; i++) ref_mem[i] = IV;
      pend = 1'b0; pwe = 1'b0; paddr = '0; pd = '0; pbe = '0;
      for (int c = 0; c < 300; c++) begin
         nxt();
         if (!pend && $urandom_range(0, 3) != 0) begin
            pend  = 1'b1;
            pwe   = 1'($urandom_range(0, 1));
            paddr = 4'($urandom_range(0, NW - 1));
            pd    = {$urandom, $urandom};
            pbe   = 8'($urandom_range(0, 255));
         end
         drive(pend, pwe, paddr, pd, pbe);
         bus.rsp_ready_i = 1'($urandom_range(0, 1));
         #1;
         if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            chk("rnd_rsp_expected",
                128'(exp_q.size() > 0), 128'(1'b1));
            if (exp_q.size() > 0) begin
               chk($sformatf("rnd_rd%0d", c),
                   128'(bus.rsp_rdata_o), 128'(exp_q.pop_front()));
            end
         end
         if (pend && bus.req_ready_o) begin
            if (pwe) begin
               for (int b = 0; b < BW; b++) begin
                  if (pbe[b]) ref_mem[paddr][b*8 +: 8] = pd[b*8 +: 8];
               end
            end else begin
               exp_q.push_back(ref_mem[paddr]);
            end
            pend = 1'b0;
         end
      end
      nxt(); drive(1'b0, 1'b0, '0, '0, '0); bus.rsp_ready_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (bus.rsp_valid_o) begin
            chk("rnd_drain_expected",
                128'(exp_q.size() > 0), 128'(1'b1));
            if (exp_q.size() > 0) begin
               chk("rnd_drain_rd",
                   128'(bus.rsp_rdata_o), 128'(exp_q.pop_front()));
            end
         end
         nxt();
      end
      chk("rnd_all_returned", 128'(exp_q.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
